// File: rtl/axi_lite_to_axi_txn_pkg.sv
// rtl/axi_lite_to_axi_txn_pkg.sv - shared constants, size helper and channel structs
// Holds the AXI response/burst encodings, the AxSIZE helper and the default
// Lite / full AXI4 request and response structs used by the converter ports.
package axi_lite_to_axi_txn_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned USER_W = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    // AxSIZE = log2(bytes per beat).
    function automatic logic [2:0] axi_size(input int unsigned data_w);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((32'd1 << i) == (data_w / 8)) s = i[2:0];
        end
        return s;
    endfunction

    typedef struct packed {
        logic [ADDR_W-1:0]   aw_addr;
        logic [2:0]          aw_prot;
        logic                aw_valid;
        logic [DATA_W-1:0]   w_data;
        logic [DATA_W/8-1:0] w_strb;
        logic                w_valid;
        logic                b_ready;
        logic [ADDR_W-1:0]   ar_addr;
        logic [2:0]          ar_prot;
        logic                ar_valid;
        logic                r_ready;
    } lite_req_s;

    typedef struct packed {
        logic                aw_ready;
        logic                w_ready;
        logic [1:0]          b_resp;
        logic                b_valid;
        logic                ar_ready;
        logic [DATA_W-1:0]   r_data;
        logic [1:0]          r_resp;
        logic                r_valid;
    } lite_resp_s;

    typedef struct packed {
        logic [ID_W-1:0]     aw_id;
        logic [ADDR_W-1:0]   aw_addr;
        logic [7:0]          aw_len;
        logic [2:0]          aw_size;
        logic [1:0]          aw_burst;
        logic                aw_lock;
        logic [3:0]          aw_cache;
        logic [2:0]          aw_prot;
        logic [3:0]          aw_qos;
        logic [3:0]          aw_region;
        logic [5:0]          aw_atop;
        logic [USER_W-1:0]   aw_user;
        logic                aw_valid;
        logic [DATA_W-1:0]   w_data;
        logic [DATA_W/8-1:0] w_strb;
        logic                w_last;
        logic [USER_W-1:0]   w_user;
        logic                w_valid;
        logic                b_ready;
        logic [ID_W-1:0]     ar_id;
        logic [ADDR_W-1:0]   ar_addr;
        logic [7:0]          ar_len;
        logic [2:0]          ar_size;
        logic [1:0]          ar_burst;
        logic                ar_lock;
        logic [3:0]          ar_cache;
        logic [2:0]          ar_prot;
        logic [3:0]          ar_qos;
        logic [3:0]          ar_region;
        logic [USER_W-1:0]   ar_user;
        logic                ar_valid;
        logic                r_ready;
    } full_req_s;

    typedef struct packed {
        logic                aw_ready;
        logic                w_ready;
        logic [ID_W-1:0]     b_id;
        logic [1:0]          b_resp;
        logic [USER_W-1:0]   b_user;
        logic                b_valid;
        logic                ar_ready;
        logic [ID_W-1:0]     r_id;
        logic [DATA_W-1:0]   r_data;
        logic [1:0]          r_resp;
        logic                r_last;
        logic [USER_W-1:0]   r_user;
        logic                r_valid;
    } full_resp_s;

endpackage

// File: rtl/axi_lite_to_axi_txn_cnt.sv
// rtl/axi_lite_to_axi_txn_cnt.sv - up/down counter saturating at 0 and at Max
// Ports: clk_i/rst_i (async active-high), inc_i/dec_i step requests,
// cnt_o current value, max_o (cnt_o >= Max), zero_o (cnt_o == 0).
module axi_lite_to_axi_txn_cnt #(
    parameter int unsigned Max = 4,
    localparam int unsigned W  = $clog2(Max + 1)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         max_o,
    output logic         zero_o
);

    localparam logic [W-1:0] MAX_V = W'(Max);

    logic [W-1:0] cnt_q, cnt_d;

    assign cnt_o  = cnt_q;
    assign max_o  = (cnt_q >= MAX_V);
    assign zero_o = (cnt_q == '0);

    // Simultaneous inc/dec cancel; a dec at 0 (stray response) is absorbed.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && !max_o) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && !zero_o) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/axi_lite_to_axi_txn.sv
// rtl/axi_lite_to_axi_txn.sv - AXI4-Lite requests to single-beat AXI4 transactions
// Ports: clk_i, rst_i (async active-high); slv_req_i/slv_resp_o Lite side;
// mst_req_o/mst_resp_i full AXI4 side; err_o sticky response-check flag,
// present only when AXI_LITE_TO_AXI_TXN_RESP_CHECK_EN is defined.
module axi_lite_to_axi_txn
    import axi_lite_to_axi_txn_pkg::*;
#(
    parameter int unsigned AxiAddrWidth    = ADDR_W,
    parameter int unsigned AxiDataWidth    = DATA_W,
    parameter int unsigned AxiIdWidth      = ID_W,
    parameter int unsigned AxiUserWidth    = USER_W,
    parameter int unsigned AxiMaxWriteTxns = 4,
    parameter int unsigned AxiMaxReadTxns  = 4,
    parameter int unsigned AxiFixedId      = 0,
    parameter logic [3:0]  AxiCache        = 4'b0000,
    parameter type lite_req_t  = axi_lite_to_axi_txn_pkg::lite_req_s,
    parameter type lite_resp_t = axi_lite_to_axi_txn_pkg::lite_resp_s,
    parameter type full_req_t  = axi_lite_to_axi_txn_pkg::full_req_s,
    parameter type full_resp_t = axi_lite_to_axi_txn_pkg::full_resp_s
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  lite_req_t  slv_req_i,
    output lite_resp_t slv_resp_o,
    output full_req_t  mst_req_o,
    input  full_resp_t mst_resp_i
`ifdef AXI_LITE_TO_AXI_TXN_RESP_CHECK_EN
    ,
    output logic       err_o
`endif
);

    localparam int unsigned WW = $clog2(AxiMaxWriteTxns + 1);
    localparam int unsigned RW = $clog2(AxiMaxReadTxns + 1);
    localparam logic [AxiIdWidth-1:0] FIXED_ID = AxiIdWidth'(AxiFixedId);
    localparam logic [2:0] SIZE = axi_size(AxiDataWidth);

    logic [WW-1:0] wr_cnt, w_cred;
    logic [RW-1:0] rd_cnt;
    logic wr_max, wr_zero, wc_max, wc_zero, rd_max, rd_zero;
    logic aw_ok, w_ok, ar_ok;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic b_bad, r_bad;

    assign b_bad = (mst_resp_i.b_id != FIXED_ID);
    assign r_bad = (mst_resp_i.r_id != FIXED_ID) || !mst_resp_i.r_last;

    assign aw_ok = !wr_max && !rst_i;
    assign ar_ok = !rd_max && !rst_i;
    assign aw_hs = slv_req_i.aw_valid && mst_resp_i.aw_ready && aw_ok;
    // W may use a credit from an earlier AW or the AW accepted this very cycle.
    assign w_ok  = (!wc_zero || aw_hs) && !rst_i;
    assign w_hs  = slv_req_i.w_valid && mst_resp_i.w_ready && w_ok;
    assign b_hs  = mst_resp_i.b_valid && slv_req_i.b_ready && !rst_i;
    assign ar_hs = slv_req_i.ar_valid && mst_resp_i.ar_ready && ar_ok;
    assign r_hs  = mst_resp_i.r_valid && slv_req_i.r_ready && !rst_i;

    axi_lite_to_axi_txn_cnt #(.Max(AxiMaxWriteTxns)) u_wr_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .inc_i(aw_hs), .dec_i(b_hs),
        .cnt_o(wr_cnt), .max_o(wr_max), .zero_o(wr_zero));

    axi_lite_to_axi_txn_cnt #(.Max(AxiMaxWriteTxns)) u_w_cred (
        .clk_i(clk_i), .rst_i(rst_i), .inc_i(aw_hs), .dec_i(w_hs),
        .cnt_o(w_cred), .max_o(wc_max), .zero_o(wc_zero));

    axi_lite_to_axi_txn_cnt #(.Max(AxiMaxReadTxns)) u_rd_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .inc_i(ar_hs), .dec_i(r_hs),
        .cnt_o(rd_cnt), .max_o(rd_max), .zero_o(rd_zero));

    always_comb begin
        mst_req_o           = '0;
        mst_req_o.aw_id     = FIXED_ID;
        mst_req_o.aw_addr   = slv_req_i.aw_addr[AxiAddrWidth-1:0];
        mst_req_o.aw_size   = SIZE;
        mst_req_o.aw_burst  = BURST_INCR;
        mst_req_o.aw_cache  = AxiCache;
        mst_req_o.aw_prot   = slv_req_i.aw_prot;
        mst_req_o.aw_user   = AxiUserWidth'(0);
        mst_req_o.aw_valid  = slv_req_i.aw_valid && aw_ok;
        mst_req_o.w_data    = slv_req_i.w_data;
        mst_req_o.w_strb    = slv_req_i.w_strb;
        mst_req_o.w_last    = 1'b1;
        mst_req_o.w_valid   = slv_req_i.w_valid && w_ok;
        mst_req_o.b_ready   = slv_req_i.b_ready && !rst_i;
        mst_req_o.ar_id     = FIXED_ID;
        mst_req_o.ar_addr   = slv_req_i.ar_addr[AxiAddrWidth-1:0];
        mst_req_o.ar_size   = SIZE;
        mst_req_o.ar_burst  = BURST_INCR;
        mst_req_o.ar_cache  = AxiCache;
        mst_req_o.ar_prot   = slv_req_i.ar_prot;
        mst_req_o.ar_user   = AxiUserWidth'(0);
        mst_req_o.ar_valid  = slv_req_i.ar_valid && ar_ok;
        mst_req_o.r_ready   = slv_req_i.r_ready && !rst_i;

        slv_resp_o          = '0;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready && aw_ok;
        slv_resp_o.w_ready  = mst_resp_i.w_ready && w_ok;
        slv_resp_o.b_valid  = mst_resp_i.b_valid && !rst_i;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready && ar_ok;
        slv_resp_o.r_data   = mst_resp_i.r_data;
        slv_resp_o.r_valid  = mst_resp_i.r_valid && !rst_i;
`ifdef AXI_LITE_TO_AXI_TXN_RESP_CHECK_EN
        slv_resp_o.b_resp   = b_bad ? RESP_SLVERR : mst_resp_i.b_resp;
        slv_resp_o.r_resp   = r_bad ? RESP_SLVERR : mst_resp_i.r_resp;
`else
        slv_resp_o.b_resp   = mst_resp_i.b_resp;
        slv_resp_o.r_resp   = mst_resp_i.r_resp;
`endif
    end

`ifdef AXI_LITE_TO_AXI_TXN_RESP_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q || (b_hs && b_bad) || (r_hs && r_bad);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err_o = err_q;
`endif

    logic unused;
    assign unused = ^{mst_resp_i.b_user, mst_resp_i.r_user, wr_zero, wc_max, rd_zero,
                      b_bad, r_bad, w_cred};

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (wr_cnt <= WW'(AxiMaxWriteTxns)) else $error("wr_cnt above max");
            assert (w_cred <= WW'(AxiMaxWriteTxns)) else $error("w_cred above max");
            assert (rd_cnt <= RW'(AxiMaxReadTxns))  else $error("rd_cnt above max");
`ifndef AXI_LITE_TO_AXI_TXN_RESP_CHECK_EN
            // With the response checker built in, these become runtime errors instead.
            if (mst_resp_i.r_valid) assert (!r_bad) else $error("R beat with bad id or last=0");
            if (mst_resp_i.b_valid) assert (!b_bad) else $error("B beat with bad id");
`endif
        end
    end
`endif

endmodule
